// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LDUSE = 3'd2,
        ST_DMISS = 3'd3,
        ST_IMISS = 3'd4
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_M   = 2'b10;
    localparam logic [1:0] FWD_W   = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// Per-source E-stage forward selector: M result wins over W, register file otherwise.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              rd_used_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    input  logic              mem_to_reg_m_i,
    output logic [1:0]        sel_o
);

    logic m_hit;
    logic w_hit;

    // A two-bubble load has not produced its data yet while it sits in M.
    assign m_hit = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i) && rd_used_i
                   && !((LOAD_LAT == 2) && mem_to_reg_m_i);
    assign w_hit = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i) && rd_used_i;

    assign sel_o = m_hit ? FWD_M : (w_hit ? FWD_W : FWD_REG);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32 core: load-use, branch/jal flush, cache-miss
// stalls, post-reset flush sequence, E-stage forwarding and saturating perf counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int LOAD_LAT      = 1,
    parameter int RST_FLUSH_CYC = 2,
    parameter int CNT_W         = 32
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST_N,
    input  logic              ICacheMiss,
    input  logic              DCacheMiss,
    input  logic              BranchE,
    input  logic              JalrE,
    input  logic              JalD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        RegReadE,
    input  logic [1:0]        RegReadD,
    input  logic              MemToRegE,
    input  logic              MemToRegM,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              FlushF,
    output logic              StallD,
    output logic              FlushD,
    output logic              StallE,
    output logic              FlushE,
    output logic              StallM,
    output logic              FlushM,
    output logic              StallW,
    output logic              FlushW,
    output logic [1:0]        Forward1E,
    output logic [1:0]        Forward2E,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    localparam int IW = $clog2(RST_FLUSH_CYC + 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic             bub_q, bub_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             run_eval;
    logic             load_use;
    logic             redirect_e;
    logic             stall_any;
    logic             flush_de;
    logic [1:0]       fwd1_raw, fwd2_raw;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign redirect_e = BranchE || JalrE;
    assign load_use   = MemToRegE && (RdE != '0)
                        && (((RdE == Rs1D) && RegReadD[1]) || ((RdE == Rs2D) && RegReadD[0]));

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        bub_d      = bub_q;
        run_eval   = 1'b0;
        {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW} = '0;

        unique case (state_q)
            ST_INIT: begin
                {FlushF, FlushD, FlushE, FlushM, FlushW} = '1;
                if (init_cnt_q <= IW'(1)) state_d = ST_RUN;
                else                      init_cnt_d = init_cnt_q - IW'(1);
            end
            ST_RUN: run_eval = 1'b1;
            ST_LDUSE: begin
                if (!bub_q) begin
                    run_eval = 1'b1;
                end else begin
                    {StallF, StallD, FlushE} = '1;
                    bub_d = 1'b0;
                end
            end
            ST_DMISS: begin
                if (DCacheMiss) {StallF, StallD, StallE, StallM, FlushW} = '1;
                else            run_eval = 1'b1;
            end
            ST_IMISS: begin
                // A branch waiting on the refill stays parked in E so its target survives.
                if (ICacheMiss && !DCacheMiss) begin
                    if (redirect_e) {StallF, StallD, StallE, FlushM} = '1;
                    else            {StallF, FlushD} = '1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            default: begin
                {FlushF, FlushD, FlushE, FlushM, FlushW} = '1;
                state_d = ST_INIT;
            end
        endcase

        if (run_eval) begin
            state_d = ST_RUN;
            if (DCacheMiss) begin
                {StallF, StallD, StallE, StallM, FlushW} = '1;
                state_d = ST_DMISS;
            end else if (load_use) begin
                {StallF, StallD, FlushE} = '1;
                bub_d   = (LOAD_LAT == 2);
                state_d = ST_LDUSE;
            end else if (redirect_e) begin
                if (ICacheMiss) begin
                    {StallF, StallD, StallE, FlushM} = '1;
                    state_d = ST_IMISS;
                end else begin
                    {FlushD, FlushE} = '1;
                end
            end else if (ICacheMiss) begin
                {StallF, FlushD} = '1;
                state_d = ST_IMISS;
            end else if (JalD) begin
                FlushD = 1'b1;
            end
        end
    end

    assign stall_any   = StallF || StallD || StallE || StallM || StallW;
    assign flush_de    = (FlushD || FlushE) && (state_q != ST_INIT);
    assign stall_cnt_d = stall_any ? sat_inc(stall_cnt_q) : stall_cnt_q;
    assign flush_cnt_d = flush_de  ? sat_inc(flush_cnt_q) : flush_cnt_q;

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= IW'(RST_FLUSH_CYC);
            bub_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            bub_q       <= bub_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

    fwd_sel #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) u_fwd1 (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .rd_used_i     (RegReadE[1]),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .mem_to_reg_m_i(MemToRegM),
        .sel_o         (fwd1_raw)
    );

    fwd_sel #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) u_fwd2 (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .rd_used_i     (RegReadE[0]),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .mem_to_reg_m_i(MemToRegM),
        .sel_o         (fwd2_raw)
    );

    assign Forward1E = (state_q == ST_INIT) ? FWD_REG : fwd1_raw;
    assign Forward2E = (state_q == ST_INIT) ? FWD_REG : fwd2_raw;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc (LOAD_LAT=2, RST_FLUSH_CYC=2, 4-bit counters so saturation is reachable).
module tb_hazard_ctrl_mc;

    localparam int AW = 5;
    localparam int CW = 4;

    localparam logic [4:0] C_IDLE = 5'b00000;  // {ICacheMiss, DCacheMiss, BranchE, JalrE, JalD}
    localparam logic [4:0] C_IM   = 5'b10000;
    localparam logic [4:0] C_DM   = 5'b01000;
    localparam logic [4:0] C_BR   = 5'b00100;
    localparam logic [4:0] C_JR   = 5'b00010;
    localparam logic [4:0] C_JD   = 5'b00001;

    // {StallF,FlushF,StallD,FlushD,StallE,FlushE,StallM,FlushM,StallW,FlushW}
    localparam logic [9:0] SF_ALL  = 10'b01_01_01_01_01;
    localparam logic [9:0] SF_NONE = 10'b00_00_00_00_00;
    localparam logic [9:0] SF_DM   = 10'b10_10_10_10_01;
    localparam logic [9:0] SF_LDU  = 10'b10_10_01_00_00;
    localparam logic [9:0] SF_BRIM = 10'b10_10_10_01_00;
    localparam logic [9:0] SF_BR   = 10'b00_01_01_00_00;
    localparam logic [9:0] SF_IM   = 10'b10_01_00_00_00;
    localparam logic [9:0] SF_JAL  = 10'b00_01_00_00_00;

    logic          CPU_CLK = 1'b0;
    logic          CPU_RST_N = 1'b0;
    logic          ICacheMiss = 1'b0, DCacheMiss = 1'b0, BranchE = 1'b0, JalrE = 1'b0, JalD = 1'b0;
    logic [AW-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic [1:0]    RegReadE = '0, RegReadD = '0;
    logic          MemToRegE = 1'b0, MemToRegM = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic          StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW;
    logic [1:0]    Forward1E, Forward2E;
    logic [CW-1:0] StallCnt, FlushCnt;

    hazard_ctrl_mc #(.REG_AW(AW), .LOAD_LAT(2), .RST_FLUSH_CYC(2), .CNT_W(CW)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
        .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegReadE(RegReadE), .RegReadD(RegReadD),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .FlushF(FlushF), .StallD(StallD), .FlushD(FlushD),
        .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
        .StallW(StallW), .FlushW(FlushW),
        .Forward1E(Forward1E), .Forward2E(Forward2E),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial forever #5 CPU_CLK = ~CPU_CLK;

    typedef struct {
        string      nm;
        logic       rst_n;
        logic [4:0] ctl;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rre, rrd;
        logic [3:0] fl;   // {MemToRegE, MemToRegM, RegWriteM, RegWriteW}
        logic [9:0] sf;
        logic [1:0] f1, f2;
        int         scnt, fcnt;  // -1: not checked on this row
    } vec_t;

    typedef struct {
        string      nm;
        logic [9:0] sf;
        logic [1:0] f1, f2;
        int         scnt, fcnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string nm, logic rst_n, logic [4:0] ctl, logic [9:0] sf);
        vec_t t;
        t.nm = nm; t.rst_n = rst_n; t.ctl = ctl;
        t.rs1d = '0; t.rs2d = '0; t.rs1e = '0; t.rs2e = '0; t.rde = '0; t.rdm = '0; t.rdw = '0;
        t.rre = '0; t.rrd = '0; t.fl = '0;
        t.sf = sf; t.f1 = 2'b00; t.f2 = 2'b00; t.scnt = -1; t.fcnt = -1;
        return t;
    endfunction

    function automatic vec_t fw(vec_t t, logic [3:0] fl, logic [4:0] rs1e, logic [4:0] rs2e,
                                logic [4:0] rdm, logic [4:0] rdw, logic [1:0] rre,
                                logic [1:0] f1, logic [1:0] f2);
        vec_t r = t;
        r.fl = fl; r.rs1e = rs1e; r.rs2e = rs2e; r.rdm = rdm; r.rdw = rdw; r.rre = rre;
        r.f1 = f1; r.f2 = f2;
        return r;
    endfunction

    function automatic vec_t ld(vec_t t, logic [4:0] rde, logic [4:0] rs1d, logic [4:0] rs2d,
                                logic [1:0] rrd);
        vec_t r = t;
        r.fl[3] = 1'b1; r.rde = rde; r.rs1d = rs1d; r.rs2d = rs2d; r.rrd = rrd;
        return r;
    endfunction

    function automatic vec_t cn(vec_t t, int s, int f);
        vec_t r = t;
        r.scnt = s; r.fcnt = f;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input string nm, input logic [9:0] sf, input logic [1:0] f1,
                            input logic [1:0] f2, input int s, input int f);
        exp_t e;
        e.nm = nm; e.sf = sf; e.f1 = f1; e.f2 = f2; e.scnt = s; e.fcnt = f;
        sb.push_back(e);
    endtask

    task automatic apply(input vec_t t);
        CPU_RST_N = t.rst_n;
        {ICacheMiss, DCacheMiss, BranchE, JalrE, JalD} = t.ctl;
        Rs1D = t.rs1d; Rs2D = t.rs2d; Rs1E = t.rs1e; Rs2E = t.rs2e;
        RdE = t.rde; RdM = t.rdm; RdW = t.rdw;
        RegReadE = t.rre; RegReadD = t.rrd;
        {MemToRegE, MemToRegM, RegWriteM, RegWriteW} = t.fl;
        push_exp(t.nm, t.sf, t.f1, t.f2, t.scnt, t.fcnt);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.nm, ".stall_flush"},
                {22'd0, StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW},
                {22'd0, e.sf});
            chk({e.nm, ".fwd1"}, {30'd0, Forward1E}, {30'd0, e.f1});
            chk({e.nm, ".fwd2"}, {30'd0, Forward2E}, {30'd0, e.f2});
            if (e.scnt >= 0) chk({e.nm, ".stall_cnt"}, {28'd0, StallCnt}, e.scnt);
            if (e.fcnt >= 0) chk({e.nm, ".flush_cnt"}, {28'd0, FlushCnt}, e.fcnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t t;
        int   nfl;

        // Reset and flush-on-release sequence; forwarding conditions present but masked.
        tbl.push_back(cn(fw(mk("rst_a", 1'b0, C_IDLE, SF_ALL), 4'b0010, 5'd7, 5'd0, 5'd7, 5'd0, 2'b10, 2'b00, 2'b00), 0, 0));
        tbl.push_back(cn(mk("rst_b", 1'b0, C_IDLE, SF_ALL), 0, 0));
        tbl.push_back(cn(fw(mk("init_1", 1'b1, C_IDLE, SF_ALL), 4'b0010, 5'd7, 5'd0, 5'd7, 5'd0, 2'b10, 2'b00, 2'b00), 0, 0));
        tbl.push_back(cn(mk("init_2", 1'b1, C_IDLE, SF_ALL), 0, 0));
        tbl.push_back(cn(mk("run_0", 1'b1, C_IDLE, SF_NONE), 0, 0));
        // lw x5 in E, add x6,x5,x1 in D: two bubbles, no M forwarding of the load.
        tbl.push_back(ld(mk("ldu_1", 1'b1, C_IDLE, SF_LDU), 5'd5, 5'd5, 5'd1, 2'b11));
        t = fw(mk("ldu_2", 1'b1, C_IDLE, SF_LDU), 4'b0110, 5'd5, 5'd0, 5'd5, 5'd0, 2'b10, 2'b00, 2'b00);
        t.rs1d = 5'd5; t.rrd = 2'b10;
        tbl.push_back(cn(t, 1, 1));
        t = fw(mk("ldu_3", 1'b1, C_IDLE, SF_NONE), 4'b0001, 5'd0, 5'd0, 5'd0, 5'd5, 2'b00, 2'b00, 2'b00);
        t.rs1d = 5'd5; t.rrd = 2'b10;
        tbl.push_back(cn(t, 2, 2));
        // Forwarding selects.
        tbl.push_back(fw(mk("fwd_ld_m_to_w", 1'b1, C_IDLE, SF_NONE), 4'b0111, 5'd5, 5'd0, 5'd5, 5'd5, 2'b10, 2'b01, 2'b00));
        tbl.push_back(fw(mk("fwd_m_prio", 1'b1, C_IDLE, SF_NONE), 4'b0011, 5'd7, 5'd0, 5'd7, 5'd7, 2'b10, 2'b10, 2'b00));
        tbl.push_back(fw(mk("fwd_w_rs2", 1'b1, C_IDLE, SF_NONE), 4'b0011, 5'd0, 5'd3, 5'd0, 5'd3, 2'b11, 2'b00, 2'b01));
        tbl.push_back(fw(mk("fwd_unused", 1'b1, C_IDLE, SF_NONE), 4'b0001, 5'd0, 5'd3, 5'd0, 5'd3, 2'b00, 2'b00, 2'b00));
        tbl.push_back(fw(mk("fwd_m_rs2", 1'b1, C_IDLE, SF_NONE), 4'b0010, 5'd9, 5'd9, 5'd9, 5'd0, 2'b01, 2'b00, 2'b10));
        tbl.push_back(fw(mk("fwd_x0", 1'b1, C_IDLE, SF_NONE), 4'b0011, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 2'b00, 2'b00));
        // D-cache miss for 4 cycles.
        tbl.push_back(cn(mk("dmiss_1", 1'b1, C_DM, SF_DM), 2, 2));
        for (int i = 0; i < 3; i++) tbl.push_back(mk("dmiss_n", 1'b1, C_DM, SF_DM));
        tbl.push_back(cn(mk("dmiss_exit", 1'b1, C_IDLE, SF_NONE), 6, 2));
        // Branch held in E across a 3-cycle I-cache miss.
        tbl.push_back(cn(mk("br_im_1", 1'b1, C_BR | C_IM, SF_BRIM), 6, 2));
        for (int i = 0; i < 2; i++) tbl.push_back(mk("br_im_n", 1'b1, C_BR | C_IM, SF_BRIM));
        tbl.push_back(mk("br_release", 1'b1, C_BR, SF_BR));
        tbl.push_back(cn(mk("br_done", 1'b1, C_IDLE, SF_NONE), 9, 3));
        // jal / jalr / plain I-miss, D-miss overriding an I-miss.
        tbl.push_back(mk("jal_d", 1'b1, C_JD, SF_JAL));
        tbl.push_back(mk("jalr_e", 1'b1, C_JR, SF_BR));
        tbl.push_back(mk("imiss_1", 1'b1, C_IM, SF_IM));
        tbl.push_back(mk("imiss_2", 1'b1, C_IM, SF_IM));
        tbl.push_back(mk("imiss_dm", 1'b1, C_IM | C_DM, SF_DM));
        tbl.push_back(mk("dm_exit_im", 1'b1, C_IM, SF_IM));
        tbl.push_back(cn(mk("im_done", 1'b1, C_IDLE, SF_NONE), 13, 8));
        // D-miss beats load-use; counter saturation at 15.
        tbl.push_back(ld(mk("dm_over_ldu", 1'b1, C_DM, SF_DM), 5'd4, 5'd4, 5'd0, 2'b10));
        tbl.push_back(ld(mk("ldu_after_dm", 1'b1, C_IDLE, SF_LDU), 5'd4, 5'd4, 5'd0, 2'b10));
        tbl.push_back(cn(mk("ldu_hold", 1'b1, C_IDLE, SF_LDU), 15, 9));
        tbl.push_back(cn(mk("stall_sat", 1'b1, C_IDLE, SF_NONE), 15, 10));
        // Load-use qualifiers.
        tbl.push_back(ld(mk("lu_rd_x0", 1'b1, C_IDLE, SF_NONE), 5'd0, 5'd0, 5'd0, 2'b11));
        tbl.push_back(ld(mk("lu_rs2_unused", 1'b1, C_IDLE, SF_NONE), 5'd4, 5'd0, 5'd4, 2'b10));
        tbl.push_back(ld(mk("lu_rs2", 1'b1, C_IDLE, SF_LDU), 5'd4, 5'd0, 5'd4, 2'b01));
        tbl.push_back(mk("lu_rs2_b", 1'b1, C_IDLE, SF_LDU));
        tbl.push_back(mk("lu_done", 1'b1, C_IDLE, SF_NONE));
        tbl.push_back(mk("dm_pre_1", 1'b1, C_DM, SF_DM));
        tbl.push_back(mk("dm_pre_2", 1'b1, C_DM, SF_DM));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge CPU_CLK);
            #1;
            apply(tbl[i]);
            @(negedge CPU_CLK);
            check_out();
        end

        // Reset asserted mid-DMISS, away from any clock edge: all-flush and cleared counters at once.
        #2;
        CPU_RST_N = 1'b0;
        #1;
        push_exp("rst_mid_dmiss", SF_ALL, 2'b00, 2'b00, 0, 0);
        check_out();

        // Release with the miss gone: exactly two flush cycles, then a quiet RUN.
        @(posedge CPU_CLK);
        #1;
        DCacheMiss = 1'b0;
        CPU_RST_N  = 1'b1;
        nfl = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CPU_CLK);
            if (!FlushD) break;
            nfl++;
        end
        chk("rst_release_flush_cycles", nfl, 2);
        push_exp("run_after_rst", SF_NONE, 2'b00, 2'b00, 0, 0);
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Next-generation pipeline hazard controller for the 5-stage RV32 core (F/D/E/M/W).
- Adds to load-use, branch/jal flush and E-stage forwarding:
  - multi-cycle cache-miss stalls (I and D) through a state machine;
  - configurable load latency (1 or 2 bubbles);
  - a registered reset-flush sequence;
  - saturating stall/flush performance counters.
- Sits beside the datapath. Drives the stall/flush of all five stage registers and the forward selects for E.

Parameters:
- REG_AW, 5, register-index width.
- LOAD_LAT, 1, load-use bubbles inserted (legal 1 or 2). With 2, M-stage load results are not forwardable.
- RST_FLUSH_CYC, 2, cycles all stages are flushed after reset release (≥1).
- CNT_W, 32, width of the performance counters.

Ports:
- CPU_CLK  in  1  core clock, rising edge.
- CPU_RST_N  in  1  asynchronous active-low reset.
- ICacheMiss, DCacheMiss  in  1 each  level signals, high while a miss is outstanding.
- BranchE, JalrE, JalD  in  1 each  taken branch / jalr resolved in E; jal in D.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW each  register indices.
- RegReadE  in  2  [1] = rs1 used, [0] = rs2 used.
- RegReadD  in  2  same meaning, D stage.
- MemToRegE, MemToRegM  in  1 each  load in E / M.
- RegWriteM, RegWriteW  in  1 each  writes rd.
- StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1 each.
- Forward1E, Forward2E  out  2 each  00 = register file, 10 = M result, 01 = W result.
- StallCnt, FlushCnt  out  CNT_W each  saturating counters.

Behaviour:
- Reset (CPU_RST_N=0):
  - State goes to INIT asynchronously; the INIT counter is loaded with RST_FLUSH_CYC.
  - Counters clear to 0.
  - Outputs while in reset and in INIT: all Flush=1, all Stall=0, Forward=00.
- Reset mid-operation: any state is abandoned immediately; no pending event survives.
- States: INIT, RUN, LDUSE, DMISS, IMISS. Stall/flush outputs are combinational from state plus inputs.
- INIT: counter decrements each cycle; go to RUN when it reaches 1.
- RUN priority, highest first:
  1. DCacheMiss → DMISS.
     - Outputs: StallF, StallD, StallE, StallM = 1; FlushW = 1.
  2. Load-use → LDUSE.
     - Condition: MemToRegE, RdE≠0, RdE matches Rs1D with RegReadD[1] or Rs2D with RegReadD[0].
     - Outputs: StallF, StallD = 1; FlushE = 1.
     - Load bubble counter := LOAD_LAT−1.
  3. BranchE or JalrE:
     - If ICacheMiss also high: StallF, StallD, StallE = 1; FlushM = 1 (branch held in E so the redirect target is not lost); go to IMISS.
     - Otherwise: FlushD, FlushE = 1.
  4. ICacheMiss → IMISS.
     - Outputs: StallF = 1; FlushD = 1.
  5. JalD → FlushD = 1.
  6. Otherwise all outputs 0.
- LDUSE:
  - When the bubble counter is 0: behave exactly as RUN this cycle.
  - Otherwise: StallF, StallD = 1; FlushE = 1; decrement.
  - With LOAD_LAT=1, LDUSE is left after one cycle.
- DMISS: hold the DMISS outputs until DCacheMiss=0, then evaluate RUN rules in that same cycle. A new ICacheMiss seen on exit → IMISS.
- IMISS: hold until ICacheMiss=0, then evaluate RUN rules in that cycle.
  - A held branch stays in E.
  - DCacheMiss rising during IMISS → DMISS, which takes priority.
- Forwarding (per source s):
  - Select M (10) when RegWriteM, RdM≠0, RdM==RsxE, RegReadE bit set, and not (LOAD_LAT==2 and MemToRegM).
  - Else select W (01) when RegWriteW, RdW≠0, RdW==RsxE, bit set.
  - Else 00.
  - Rs1 uses RegReadE[1]; Rs2 uses RegReadE[0].
  - Forward values are masked to 00 in INIT.
- Counters:
  - StallCnt +1 each cycle any Stall is 1.
  - FlushCnt +1 each cycle FlushD or FlushE is 1 outside INIT.
  - Both saturate at all-ones and do not wrap.

Decomposition:
- Shared package `hazard_pkg`:
  - state enum (INIT, RUN, LDUSE, DMISS, IMISS);
  - forward-select constants FWD_REG=2'b00, FWD_M=2'b10, FWD_W=2'b01.
- One sub-module, `fwd_sel`: combinational per-source forward selector, instantiated twice.

Test Plan:
- Reset release with RST_FLUSH_CYC=2: all Flush=1 for exactly 2 cycles after CPU_RST_N rises, then 0; StallCnt=FlushCnt=0.
- LOAD_LAT=2: lw x5 in E, add x6,x5,x1 in D → StallF/StallD=1 and FlushE=1 for 2 cycles; Forward1E≠10 while the load is in M.
- DCacheMiss high 4 cycles: StallF..StallM=1 and FlushW=1 for 4 cycles; StallCnt=4; resumes RUN on the 5th cycle.
- BranchE and ICacheMiss together for 3 cycles: StallE=1 and FlushM=1 for 3 cycles; then FlushD=FlushE=1 in the cycle ICacheMiss drops.
- RdM=RdW=Rs1E=7, both writing → Forward1E=10; RdM=0 with RdW=Rs2E=3 and RegReadE[0]=1 → Forward2E=01; RegReadE[0]=0 → Forward2E=00.
- Assert CPU_RST_N=0 mid-DMISS: outputs switch to all-flush immediately; state goes to INIT; counters clear to 0.
